// File: rtl/seg_scan_driver_if.sv
// Display-side bundle for seg_scan_driver: divider strobes, BCD digits, drive.
// master = time/divider source and display sink, slave = scan driver.
interface seg_scan_driver_if;
  logic       clk500Hz;
  logic       clk3Hz;
  logic       clk2s;
  logic       blink_min;
  logic       blink_hour;
  logic [3:0] hourTens;
  logic [3:0] hourOnes;
  logic [3:0] minTens;
  logic [3:0] minOnes;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output clk500Hz, clk3Hz, clk2s,
    output blink_min, blink_hour,
    output hourTens, hourOnes, minTens, minOnes,
    input  an, seg, dp
  );

  modport slave (
    input  clk500Hz, clk3Hz, clk2s,
    input  blink_min, blink_hour,
    input  hourTens, hourOnes, minTens, minOnes,
    output an, seg, dp
  );
endinterface

// File: rtl/seg_scan_driver.sv
// 4-digit multiplexed 7-seg scan driver with anti-ghost blank gap.
// Optional LEADING_ZERO_BLANK_EN blanks a zero hour-tens digit.
module seg_scan_driver #(
  parameter int BLANK_CYCLES = 50,
  parameter int BLANK_W      = 12
) (
  input logic              clk5MHz,
  input logic              rst_n,
  seg_scan_driver_if.slave bus
);

  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  localparam logic [BLANK_W-1:0] LP_TERM =
    BLANK_W'(BLANK_CYCLES - 1);
  localparam logic [6:0] LP_OFF  = 7'h7F;
  localparam logic [6:0] LP_DASH = 7'b0111111;

  logic               r_s500_q;
  logic               r_s500_qq;
  logic               r_s3_q;
  logic               r_s2_q;
  logic [1:0]         r_state;
  logic [1:0]         r_idx;
  logic [BLANK_W-1:0] r_cnt;
  logic [15:0]        r_snap;
  logic [3:0]         r_an;
  logic [6:0]         r_seg;
  logic               r_dp;

  logic               w_tick;
  logic [1:0]         w_state_n;
  logic [1:0]         w_idx_n;
  logic [BLANK_W-1:0] w_cnt_n;
  logic [15:0]        w_snap_n;
  logic [15:0]        w_digits;
  logic [3:0]         w_dig;
  logic               w_blink;
  logic [3:0]         w_an_n;
  logic [6:0]         w_seg_n;
  logic               w_dp_n;

  assign w_tick   = r_s500_q & ~r_s500_qq;
  assign w_digits = {bus.hourTens, bus.hourOnes,
                     bus.minTens, bus.minOnes};

  function automatic logic [6:0] f_dec(input logic [3:0] d);
    logic [6:0] s;
    s = LP_DASH;
    case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = LP_DASH;
    endcase
    return s;
  endfunction

  // A tick always restarts the gap; the frame snapshot is
  // taken only when the scan wraps back to digit 0.
  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_cnt_n   = r_cnt;
    w_snap_n  = r_snap;
    unique case (1'b1)
      (r_state == S_OFF): begin
        if (w_tick) begin
          w_state_n = S_BLANK;
          w_idx_n   = 2'd0;
          w_cnt_n   = '0;
          w_snap_n  = w_digits;
        end
      end
      (r_state == S_BLANK),
      (r_state == S_SHOW): begin
        if (w_tick) begin
          w_state_n = S_BLANK;
          w_idx_n   = r_idx + 2'd1;
          w_cnt_n   = '0;
          if (r_idx == 2'd3)
            w_snap_n = w_digits;
        end else if (r_state == S_BLANK) begin
          if (r_cnt == LP_TERM)
            w_state_n = S_SHOW;
          else
            w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: w_state_n = S_OFF;
    endcase
  end

  assign w_dig   = w_snap_n[{w_idx_n, 2'b00} +: 4];
  assign w_blink = ~r_s3_q &
    (w_idx_n[1] ? bus.blink_hour : bus.blink_min);

  always_comb begin
    w_an_n  = 4'hF;
    w_seg_n = LP_OFF;
    w_dp_n  = 1'b1;
    if (w_state_n == S_SHOW) begin
      w_an_n  = ~(4'b0001 << w_idx_n);
      w_seg_n = w_blink ? LP_OFF : f_dec(w_dig);
`ifdef LEADING_ZERO_BLANK_EN
      if (w_idx_n == 2'd3 && w_dig == 4'd0)
        w_seg_n = LP_OFF;
`endif
      w_dp_n  = ~(w_idx_n == 2'd2 && r_s2_q);
    end
  end

  always_ff @(posedge clk5MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_s500_q  <= 1'b0;
      r_s500_qq <= 1'b0;
      r_s3_q    <= 1'b0;
      r_s2_q    <= 1'b0;
      r_state   <= S_OFF;
      r_idx     <= 2'd0;
      r_cnt     <= '0;
      r_snap    <= '0;
      r_an      <= 4'hF;
      r_seg     <= LP_OFF;
      r_dp      <= 1'b1;
    end else begin
      r_s500_q  <= bus.clk500Hz;
      r_s500_qq <= r_s500_q;
      r_s3_q    <= bus.clk3Hz;
      r_s2_q    <= bus.clk2s;
      r_state   <= w_state_n;
      r_idx     <= w_idx_n;
      r_cnt     <= w_cnt_n;
      r_snap    <= w_snap_n;
      r_an      <= w_an_n;
      r_seg     <= w_seg_n;
      r_dp      <= w_dp_n;
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;

endmodule
